// File: rtl/div_pkg.sv
// Shared constants for the restoring divider: FSM encodings and counter sizing.
package div_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Iteration counter width: ceil(log2(n)), never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sub_cl.sv
// Combinational subtractor a - b computed as a + ~b + 1 on a
// generate/propagate carry structure; borrow is the inverted carry out.
module sub_cl #(
  parameter int unsigned W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         borrow
);

  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W:0]   c;

  assign g = a & ~b;
  assign p = a ^ ~b;

  // Carry chain from per-bit generate/propagate, carry-in fixed at 1.
  always_comb begin
    c    = '0;
    c[0] = 1'b1;
    for (int unsigned i = 0; i < W; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
  end

  assign diff   = p ^ c[W-1:0];
  assign borrow = ~c[W];

endmodule

// File: rtl/div_restoring.sv
// Sequential unsigned restoring divider: one quotient bit per RUN cycle,
// divide-by-zero short-circuits straight to DONE.
module div_restoring
  import div_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int unsigned CW = cnt_width(N);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [N-1:0]  rem_q;
  logic [N-1:0]  quo_q;
  logic [N-1:0]  dvs_q;
  logic          dbz_q;

  logic [N:0]    shifted;
  logic [N:0]    diff;
  logic          borrow;
  logic          keep;

  // {rem,q} shifted left by one: upper N+1 bits feed the trial subtraction.
  assign shifted = {rem_q, quo_q[N-1]};

  sub_cl #(.W(N+1)) u_sub (
    .a      (shifted),
    .b      ({1'b0, dvs_q}),
    .diff   (diff),
    .borrow (borrow)
  );

  // diff[N] is always 0 when there is no borrow; folding it in makes explicit
  // that the kept difference fits the N-bit remainder register.
  assign keep = ~borrow & ~diff[N];

  // FSM plus datapath registers; results stay in quo_q/rem_q until next start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      dbz_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            dvs_q <= divisor;
            cnt   <= CW'(N - 1);
            if (divisor == '0) begin
              quo_q <= '1;
              rem_q <= dividend;
              dbz_q <= 1'b1;
              state <= S_DONE;
            end else begin
              quo_q <= dividend;
              rem_q <= '0;
              dbz_q <= 1'b0;
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          quo_q <= {quo_q[N-2:0], keep};
          rem_q <= keep ? diff[N-1:0] : shifted[N-1:0];
          if (cnt == '0) begin
            state <= S_DONE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy        = (state == S_RUN);
  assign done        = (state == S_DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_restoring.sv
// Scoreboard bench for div_restoring (N=4): expected results queued at
// start, compared when done pulses, including latency and invariants.
module tb_div_restoring;

  localparam int unsigned N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dbz;
    int unsigned  cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  logic        busy_seen = 1'b0;

  div_restoring #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Output monitor: exclusivity every cycle, scoreboard compare on done.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (busy) busy_seen = 1'b1;
      check("busy_done_excl", 32'(busy & done), 32'd0);
      if (done) begin
        if (sb.size() == 0) begin
          check("spurious_done", 32'(done), 32'd0);
        end else begin
          e = sb.pop_front();
          check("quotient", 32'(quotient), 32'(e.q));
          check("remainder", 32'(remainder), 32'(e.r));
          check("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
          check("latency", cyc, e.cyc);
          if (e.b != 0) begin
            check("identity", 32'(quotient) * 32'(e.b) + 32'(remainder), 32'(e.a));
            check("rem_lt_div", 32'(remainder < e.b), 32'd1);
          end
        end
      end
    end
  end

  task automatic run_div(input logic [N-1:0] a, input logic [N-1:0] b, input bit push);
    int unsigned guard = 0;
    exp_t x;
    @(negedge clk);
    while ((busy || done) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check("idle_timeout", guard, 32'd0);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    if (push) begin
      x.a   = a;
      x.b   = b;
      x.q   = (b == 0) ? '1 : N'(a / b);
      x.r   = (b == 0) ? a  : N'(a % b);
      x.dbz = (b == 0);
      x.cyc = cyc + 1 + ((b == 0) ? 0 : N);
      sb.push_back(x);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain();
    int unsigned guard = 0;
    while (sb.size() != 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("drain", sb.size(), 32'd0);
  endtask

  initial begin
    rst_n    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    // Basic divisions and result hold after done.
    run_div(4'd13, 4'd4, 1'b1);
    wait_drain();
    repeat (3) @(negedge clk);
    check("hold_quotient", 32'(quotient), 32'd3);
    check("hold_remainder", 32'(remainder), 32'd1);
    run_div(4'd15, 4'd1, 1'b1);
    run_div(4'd3, 4'd9, 1'b1);
    wait_drain();

    // Divide by zero: no RUN cycle, flag cleared by the next accepted start.
    busy_seen = 1'b0;
    run_div(4'd7, 4'd0, 1'b1);
    wait_drain();
    check("dbz_no_busy", 32'(busy_seen), 32'd0);
    run_div(4'd13, 4'd4, 1'b1);
    check("dbz_cleared", 32'(div_by_zero), 32'd0);
    wait_drain();

    // Start and operand changes while busy are ignored.
    run_div(4'd14, 4'd3, 1'b1);
    start    = 1'b1;
    dividend = 4'd9;
    divisor  = 4'd2;
    @(negedge clk);
    start    = 1'b0;
    dividend = 4'd5;
    divisor  = 4'd1;
    wait_drain();
    repeat (8) @(negedge clk);

    // Reset during the third RUN cycle aborts without a done pulse.
    run_div(4'd11, 4'd2, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_quotient", 32'(quotient), 32'd0);
    check("abort_remainder", 32'(remainder), 32'd0);
    repeat (3) @(negedge clk);
    check("abort_no_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    run_div(4'd10, 4'd3, 1'b1);
    wait_drain();

    // Exhaustive sweep of every operand pair.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_div(N'(a), N'(b), 1'b1);
      end
    end
    wait_drain();
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
